// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Holds the bus widths, enable/reset levels and the fetch-queue entry layout.
package if_fetch_pkg;

  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        ChipEnable  = 1'b1;
  localparam logic        ChipDisable = 1'b0;
  localparam logic        RstEnable   = 1'b1;

  localparam int unsigned FetchQDepth = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus: ROM fetch port, EX redirect and IF/ID valid/ready handshake.
// Signal names keep the direction suffixes seen from the fetch stage.
interface if_fetch_if;

  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        id_ready_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;

  modport master (
    output rom_ce, rom_addr, id_valid_o, id_pc_o, id_inst_o,
    input  rom_inst, branch_flag_i, branch_target_i, id_ready_i
  );

  modport slave (
    input  rom_ce, rom_addr, id_valid_o, id_pc_o, id_inst_o,
    output rom_inst, branch_flag_i, branch_target_i, id_ready_i
  );

endinterface

// File: rtl/fetch_fifo.sv
// Fetch queue of {pc, inst} entries: synchronous write, combinational head read.
// Flush wins over push/pop; an empty queue presents an all-zero head.
module fetch_fifo
  import if_fetch_pkg::*;
#(
  parameter int unsigned Depth = FetchQDepth
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  fq_entry_t wdata,
  output logic      full,
  output logic      empty,
  output fq_entry_t head
);

  localparam int unsigned     PtrW      = $clog2(Depth);
  localparam logic [PtrW:0]   FullCount = (PtrW + 1)'(Depth);

  fq_entry_t       mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            wr_en, rd_en;

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);
  assign wr_en = push && !full && !flush;
  assign rd_en = pop && !empty && !flush;
  assign head  = empty ? '{pc: ZeroWord, inst: ZeroWord} : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (wr_en && !rd_en) begin
        count_q <= count_q + (PtrW + 1)'(1);
      end else if (!wr_en && rd_en) begin
        count_q <= count_q - (PtrW + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, drives the ROM and queues {pc, inst}
// pairs for IF/ID. An EX redirect flushes the queue and reloads the PC.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = FetchQDepth
) (
  input  logic         clk,
  input  logic         rst,
  if_fetch_if.master   bus
);

  logic        started_q;
  logic [31:0] fetch_pc_q;
  logic        fq_full, fq_empty, push, pop;
  fq_entry_t   fq_wdata, fq_head;

  // Full check uses the registered count, so a same-cycle pop still leaves a bubble.
  assign bus.rom_ce   = (started_q && !fq_full) ? ChipEnable : ChipDisable;
  assign bus.rom_addr = fetch_pc_q;

  assign push     = (bus.rom_ce == ChipEnable) && !bus.branch_flag_i;
  assign pop      = !fq_empty && bus.id_ready_i && !bus.branch_flag_i;
  assign fq_wdata = '{pc: fetch_pc_q, inst: bus.rom_inst};

  assign bus.id_valid_o = !fq_empty;
  assign bus.id_pc_o    = fq_head.pc;
  assign bus.id_inst_o  = fq_head.inst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      started_q  <= 1'b0;
      fetch_pc_q <= RESET_PC;
    end else begin
      started_q <= 1'b1;
      if (bus.branch_flag_i) begin
        fetch_pc_q <= bus.branch_target_i & ~32'h0000_0003;
      end else if (push) begin
        fetch_pc_q <= fetch_pc_q + 32'd4;
      end
    end
  end

  fetch_fifo #(
    .Depth (FQ_DEPTH)
  ) u_fetch_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.branch_flag_i),
    .wdata (fq_wdata),
    .full  (fq_full),
    .empty (fq_empty),
    .head  (fq_head)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a per-cycle vector table plus hand-written
// async-reset and PC wrap-around sequences on a second instance.
module tb_if_fetch;

  logic clk;
  logic rst;

  if_fetch_if bus0();
  if_fetch_if bus1();

  if_fetch #(
    .RESET_PC (32'h0000_0000),
    .FQ_DEPTH (4)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  if_fetch #(
    .RESET_PC (32'hFFFF_FFF8),
    .FQ_DEPTH (4)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // ROM model: inst_mem[k] = 0x13 + k, k = word index.
  assign bus0.rom_inst = 32'h0000_0013 + {2'b00, bus0.rom_addr[31:2]};
  assign bus1.rom_inst = 32'h0000_0013 + {2'b00, bus1.rom_addr[31:2]};

  assign bus1.id_ready_i      = 1'b1;
  assign bus1.branch_flag_i   = 1'b0;
  assign bus1.branch_target_i = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ready;
    logic        br;
    logic [31:0] tgt;
    logic        ce;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  task automatic add(input logic r, input logic rdy, input logic br, input logic [31:0] tgt,
                     input logic ce, input logic [31:0] addr, input logic v,
                     input logic [31:0] pc, input logic [31:0] inst);
    vec_t t;
    t.rst = r; t.ready = rdy; t.br = br; t.tgt = tgt;
    t.ce = ce; t.addr = addr; t.valid = v; t.pc = pc; t.inst = inst;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_dut0(input string tag, input logic ce, input logic [31:0] addr,
                            input logic v, input logic [31:0] pc, input logic [31:0] inst);
    check({tag, "_ce"},    {31'b0, bus0.rom_ce},     {31'b0, ce});
    check({tag, "_addr"},  bus0.rom_addr,            addr);
    check({tag, "_valid"}, {31'b0, bus0.id_valid_o}, {31'b0, v});
    check({tag, "_pc"},    bus0.id_pc_o,             pc);
    check({tag, "_inst"},  bus0.id_inst_o,           inst);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus0.id_ready_i      = 1'b1;
    bus0.branch_flag_i   = 1'b0;
    bus0.branch_target_i = 32'h0;

    // rst rdy br tgt | ce addr valid pc inst  (one row per cycle)
    add(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   32'h0);
    add(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   32'h0);
    add(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   32'h0);
    add(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0,   32'h13);
    add(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4,   32'h14);
    add(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h8,   32'h15);
    add(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'hC,   32'h16);
    // Reset mid-stream, then stall from the start until the queue fills.
    add(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   32'h0);
    add(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   32'h0);
    add(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   32'h0);
    add(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0,   32'h13);
    add(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h0,   32'h13);
    add(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h0,   32'h13);
    add(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h0,   32'h13);
    add(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h0,   32'h13);
    // Release: pop pc 0 with ce low (bubble), then fetch resumes at 0x10.
    add(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h0,   32'h13);
    add(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h4,   32'h14);
    // Redirect with three entries queued.
    add(1'b0, 1'b1, 1'b1, 32'h102, 1'b1, 32'h14,  1'b1, 32'h8,   32'h15);
    add(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,   32'h0);
    add(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100, 32'h53);
    // Back-to-back redirects: only 0x80 survives.
    add(1'b0, 1'b1, 1'b1, 32'h40,  1'b1, 32'h108, 1'b1, 32'h104, 32'h54);
    add(1'b0, 1'b1, 1'b1, 32'h80,  1'b1, 32'h40,  1'b0, 32'h0,   32'h0);
    add(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h80,  1'b0, 32'h0,   32'h0);
    add(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h84,  1'b1, 32'h80,  32'h33);
    add(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h88,  1'b1, 32'h84,  32'h34);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst                  = vecs[i].rst;
      bus0.id_ready_i      = vecs[i].ready;
      bus0.branch_flag_i   = vecs[i].br;
      bus0.branch_target_i = vecs[i].tgt;
      @(negedge clk);
      check_dut0($sformatf("v%0d", i), vecs[i].ce, vecs[i].addr, vecs[i].valid,
                 vecs[i].pc, vecs[i].inst);
    end

    // Async reset pulse not aligned to the clock.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_dut0("arst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    check("arst_dut1_addr", bus1.rom_addr, 32'hFFFF_FFF8);
    check("arst_dut1_ce", {31'b0, bus1.rom_ce}, 32'h0);
    #2 rst = 1'b0;
    #1;
    check("gap_ce", {31'b0, bus0.rom_ce}, 32'h0);

    @(negedge clk);
    check_dut0("rs0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    check("wrap0_ce", {31'b0, bus1.rom_ce}, 32'h1);
    check("wrap0_addr", bus1.rom_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    check_dut0("rs1", 1'b1, 32'h4, 1'b1, 32'h0, 32'h13);
    check("wrap1_pc", bus1.id_pc_o, 32'hFFFF_FFF8);
    check("wrap1_inst", bus1.id_inst_o, 32'h4000_0011);
    @(negedge clk);
    check("rs2_pc", bus0.id_pc_o, 32'h4);
    check("wrap2_pc", bus1.id_pc_o, 32'hFFFF_FFFC);
    check("wrap2_inst", bus1.id_inst_o, 32'h4000_0012);
    @(negedge clk);
    check("rs3_pc", bus0.id_pc_o, 32'h8);
    check("wrap3_pc", bus1.id_pc_o, 32'h0);
    check("wrap3_inst", bus1.id_inst_o, 32'h13);
    check("wrap3_addr", bus1.rom_addr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage that sits directly upstream of the instruction ROM. It owns the fetch PC and drives the ROM chip-enable and address. The ROM returns its instruction combinationally in the same cycle. The block captures each {pc, inst} pair into a small fetch queue and presents it to the IF/ID register through a valid/ready handshake. Branch redirects from EX flush the queue and reload the PC.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset release.
FQ_DEPTH, 4, fetch-queue entries; must be a power of two, minimum 2.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
rom_ce  output  1  ROM chip enable (`ChipEnable / `ChipDisable).
rom_addr  output  32  byte address of the current fetch; bits [1:0] always 2'b00.
rom_inst  input  32  instruction from the ROM; valid in the same cycle as rom_ce/rom_addr.
branch_flag_i  input  1  redirect request from EX.
branch_target_i  input  32  redirect byte address.
id_ready_i  input  1  downstream (IF/ID) accepts the head entry this cycle.
id_valid_o  output  1  head entry present.
id_pc_o  output  32  PC of the head entry.
id_inst_o  output  32  instruction of the head entry.

Behaviour:
- Reset: asynchronous, active-high (rst=1), on a single clock clk. While rst=1: fetch_pc=RESET_PC, queue empty, started=0, rom_ce=`ChipDisable, rom_addr=RESET_PC, id_valid_o=0, id_pc_o=`ZeroWord, id_inst_o=`ZeroWord.
- started: register set to 1 on the first clk edge after rst falls. rom_ce=1 requires started=1, so there is one cycle with ce low after release.
- rom_ce = started && (count != FQ_DEPTH). The queue-full check is combinational on the registered count.
- rom_addr = fetch_pc (registered). It is driven even when rom_ce=0.
- push = rom_ce && !branch_flag_i. On push: the queue writes {fetch_pc, rom_inst} at wr_ptr, and fetch_pc <= fetch_pc + 4. The addition is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0.
- pop = id_valid_o && id_ready_i && !branch_flag_i. On pop, rd_ptr advances.
- Push and pop in the same cycle: both take effect and count is unchanged.
- Full queue: rom_ce is low and nothing is pushed, even if a pop occurs that cycle. The free slot is used the next cycle, which costs one bubble by design.
- Empty queue: id_valid_o=0 and id_pc_o/id_inst_o=`ZeroWord. id_ready_i is ignored.
- Redirect (branch_flag_i=1), which overrides everything else:
  - Queue is flushed: count=0 and pointers reset.
  - fetch_pc <= {branch_target_i[31:2], 2'b00}.
  - No push and no pop that cycle. The head offered that cycle is discarded, even if id_ready_i=1.
  - The first fetch from the target happens the following cycle.
- Back-to-back redirects: each one reloads the PC and flushes; the last one wins.
- Pointers: log2(FQ_DEPTH) bits and wrap naturally. count is log2(FQ_DEPTH)+1 bits.
- Outputs id_*: combinational from the queue head register, with no extra latency.
- Latency: an instruction fetched in cycle N is visible on id_* from cycle N+1.
- Reset asserted mid-operation: immediate return to the reset state. Any in-flight queue contents are lost.

Decomposition:
- define.v gains `FetchQDepth (default 4) and `FetchQDepthLog2, alongside the existing `InstAddrBus, `InstBus, `ZeroWord, `ChipEnable/`ChipDisable and `RstEnable.
- The new `RstEnable is 1'b1, used asynchronously.
- One sub-module: fetch_fifo, a synchronous-write, combinational-read FIFO of 64-bit {pc,inst} entries.
  - Inputs: push, pop, flush.
  - Outputs: full, empty, head.
- if_fetch holds fetch_pc, started, the ce logic and the redirect logic.

Test Plan:
- Reset release, RESET_PC=0, id_ready_i=1, ROM holding inst_mem[k]=32'h0000_0013+k:
  - rom_ce=0 in the first cycle after release.
  - Then id_* shows pc 0,4,8,… with inst 13,14,15,… one entry per cycle, with no gaps.
- id_ready_i=0 from the start:
  - Exactly 4 pushes (pc 0..C), then rom_ce=0 and rom_addr=32'h10 held.
  - On raising id_ready_i: head pc=0 pops, one bubble, then pc=0x10 is fetched.
- Redirect with 3 entries queued, branch_flag_i=1, branch_target_i=32'h0000_0102:
  - In that cycle, no pop occurs even though id_ready_i=1.
  - Next cycle, id_valid_o=0 and rom_addr=32'h100.
  - The following cycle, id_pc_o=32'h100.
- Two consecutive redirect cycles (targets 0x40, then 0x80): the fetch resumes at 0x80 only, and no 0x40 entry ever reaches id_*.
- Wrap-around: RESET_PC=32'hFFFF_FFF8 → fetched pcs are FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Asynchronous reset pulse mid-stream, not aligned to clk:
  - All outputs return to reset values immediately.
  - Fetching restarts at RESET_PC after the one-cycle ce-low gap.
